// File: rtl/rf256_arb_ctrl.sv
// rf256_arb_ctrl: two-port arbiter and sequencer for the single-port
// 256x32 register-file macro (rflp256x32mx2).
//
// After reset the macro contents are unknown, so the controller first
// sweeps every word with INIT_VAL (INIT state). It then arbitrates between
// two requesters (RUN state) and issues one macro access per cycle.
//
// Handshake (both ports): a requester raises Px_REQ with Px_WE/Px_ADDR/
// Px_WDATA and holds all four stable until it samples Px_GNT=1 at a rising
// CLK edge. That edge is the accept edge k. Px_GNT is combinational from
// Px_REQ, the controller state and the round-robin pointer. At most one
// grant is high per cycle, and a grant is only high while its request is.
// The command is registered at k, the macro samples it at k+1, and for a
// read Px_RDATA is loaded from MEM_DO at k+2 with Px_RVALID high for that
// one cycle.
//
// Ports:
//   CLK, NRST                  clock (shared with the macro), async active-low reset
//   Px_REQ/WE/ADDR/WDATA       requester command inputs, x = 0,1
//   Px_GNT                     combinational grant
//   Px_RVALID/Px_RDATA         read return to the port that issued the read
//   INIT_DONE                  high once the clear sweep has finished
//   MEM_DIN/RA/CA/NWRT/NCE     registered macro command (active-low strobes)
//   MEM_DO                     macro read data
//   DBG_STATE                  controller state, 0 = INIT, 1 = RUN
module rf256_arb_ctrl #(
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_VAL   = 32'h0,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        P0_REQ,
  input  logic        P0_WE,
  input  logic [7:0]  P0_ADDR,
  input  logic [31:0] P0_WDATA,
  output logic        P0_GNT,
  output logic        P0_RVALID,
  output logic [31:0] P0_RDATA,
  input  logic        P1_REQ,
  input  logic        P1_WE,
  input  logic [7:0]  P1_ADDR,
  input  logic [31:0] P1_WDATA,
  output logic        P1_GNT,
  output logic        P1_RVALID,
  output logic [31:0] P1_RDATA,
  output logic        INIT_DONE,
  output logic [31:0] MEM_DIN,
  output logic [5:0]  MEM_RA,
  output logic [1:0]  MEM_CA,
  output logic        MEM_NWRT,
  output logic        MEM_NCE,
  input  logic [31:0] MEM_DO,
  output logic        DBG_STATE
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  init_cnt;
  logic [8:0]  init_cnt_nxt;
  logic        init_wr;
  logic        init_done_q;

  // Round-robin pointer: the port that won the last accepted transfer.
  // Reset to 1 so that port 0 wins the first tie.
  logic        last_q;

  logic        gnt0;
  logic        gnt1;
  logic        acc;
  logic        acc_port;
  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;

  // Read-return pipeline: stage 1 follows the accept edge, stage 2 follows
  // the macro sampling edge.
  logic        s1_v;
  logic        s1_p;
  logic        s2_v;
  logic        s2_p;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state       <= ST_RESET;
      init_cnt    <= 9'd0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      init_done_q <= (state_nxt == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. The counter's bit 8 marks that address 255 has been
  // issued; the following cycle is spent leaving INIT with no command.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_wr      = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt[8]) begin
          state_nxt = ST_RUN;
        end else begin
          init_wr      = 1'b1;
          init_cnt_nxt = init_cnt + 9'd1;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign INIT_DONE = init_done_q;
  assign DBG_STATE = (state == ST_RUN);

  // ---------------------------------------------------------------------
  // Arbitration. Grants are gated by the registered done flag so that no
  // grant can appear while NRST is low, even when the sweep is disabled.
  // ---------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (init_done_q && (state == ST_RUN)) begin
      if (P0_REQ && P1_REQ) begin
        if (FIXED_PRIO || last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = P0_REQ;
        gnt1 = P1_REQ;
      end
    end
  end

  assign P0_GNT    = gnt0;
  assign P1_GNT    = gnt1;
  assign acc       = gnt0 | gnt1;
  assign acc_port  = gnt1;
  assign acc_we    = gnt1 ? P1_WE    : P0_WE;
  assign acc_addr  = gnt1 ? P1_ADDR  : P0_ADDR;
  assign acc_wdata = gnt1 ? P1_WDATA : P0_WDATA;

  // ---------------------------------------------------------------------
  // Macro command register. Address and DIN hold when idle; a read leaves
  // DIN at the last written value.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      MEM_NCE  <= 1'b1;
      MEM_NWRT <= 1'b1;
      MEM_DIN  <= 32'h0;
      MEM_RA   <= 6'd0;
      MEM_CA   <= 2'd0;
      last_q   <= 1'b1;
    end else if (init_wr) begin
      MEM_NCE  <= 1'b0;
      MEM_NWRT <= 1'b0;
      MEM_RA   <= init_cnt[7:2];
      MEM_CA   <= init_cnt[1:0];
      MEM_DIN  <= INIT_VAL;
    end else if (acc) begin
      MEM_NCE  <= 1'b0;
      MEM_NWRT <= ~acc_we;
      MEM_RA   <= acc_addr[7:2];
      MEM_CA   <= acc_addr[1:0];
      if (acc_we) begin
        MEM_DIN <= acc_wdata;
      end
      last_q   <= acc_port;
    end else begin
      MEM_NCE  <= 1'b1;
      MEM_NWRT <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Read return. Reset drops any in-flight read.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s1_v      <= 1'b0;
      s1_p      <= 1'b0;
      s2_v      <= 1'b0;
      s2_p      <= 1'b0;
      P0_RVALID <= 1'b0;
      P1_RVALID <= 1'b0;
      P0_RDATA  <= 32'h0;
      P1_RDATA  <= 32'h0;
    end else begin
      s1_v      <= acc & ~acc_we;
      s1_p      <= acc_port;
      s2_v      <= s1_v;
      s2_p      <= s1_p;
      P0_RVALID <= s2_v & ~s2_p;
      P1_RVALID <= s2_v & s2_p;
      if (s2_v && !s2_p) begin
        P0_RDATA <= MEM_DO;
      end
      if (s2_v && s2_p) begin
        P1_RDATA <= MEM_DO;
      end
    end
  end

endmodule
